bp_cce_dir_row_updater: RTL and testbench

Write-side companion to the CCE directory tag checker: applies a single directory entry update (tag/state write, state-only write, or tag-set invalidate) to one row of the directory RAM. It performs a read-modify-write over a single-port synchronous RAM interface and returns the prior entry to the CCE. It sits between the CCE instruction datapath and the directory RAM. Its row layout is identical to the one the tag checker consumes.

---
 rtl/bp_cce_dir_row_updater_if.sv | 60 ++++++
 rtl/bp_cce_dir_row_updater.sv | 163 ++++++++++++++++
 tb/tb_bp_cce_dir_row_updater.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_cce_dir_row_updater_if.sv
// Coherence state encoding shared with the tag checker, plus the request,
// response and directory-RAM bundle seen by the row updater.
package bp_cce_dir_pkg;
  typedef enum logic [2:0] {
    e_COH_I = 3'b000,
    e_COH_S = 3'b001,
    e_COH_E = 3'b010,
    e_COH_F = 3'b011,
    e_COH_M = 3'b110,
    e_COH_O = 3'b111
  } bp_coh_states_e;
endpackage

interface bp_cce_dir_row_updater_if #(
  parameter int tag_sets_per_row_p = 2,
  parameter int assoc_p            = 2,
  parameter int tag_width_p        = 8,
  parameter int rows_p             = 4
) ();
  localparam int entry_width_lp  = tag_width_p + $bits(bp_cce_dir_pkg::bp_coh_states_e);
  localparam int row_width_lp    = tag_sets_per_row_p * assoc_p * entry_width_lp;
  localparam int addr_width_lp   = (rows_p > 1) ? $clog2(rows_p) : 1;
  localparam int row_in_width_lp = addr_width_lp + 1;
  localparam int set_width_lp    = (tag_sets_per_row_p > 1) ? $clog2(tag_sets_per_row_p) : 1;
  localparam int way_width_lp    = (assoc_p > 1) ? $clog2(assoc_p) : 1;

  logic                                v_i;
  logic                                ready_o;
  logic [1:0]                          cmd_i;
  logic [row_in_width_lp-1:0]          row_i;
  logic [set_width_lp-1:0]             tag_set_i;
  logic [way_width_lp-1:0]             way_i;
  logic [tag_width_p-1:0]              tag_i;
  bp_cce_dir_pkg::bp_coh_states_e      state_i;
  logic                                v_o;
  logic                                yumi_i;
  logic [tag_width_p-1:0]              old_tag_o;
  bp_cce_dir_pkg::bp_coh_states_e      old_state_o;
  logic                                err_o;
  logic                                ram_v_o;
  logic                                ram_w_o;
  logic [addr_width_lp-1:0]            ram_addr_o;
  logic [row_width_lp-1:0]             ram_data_o;
  logic                                ram_ready_i;
  logic [row_width_lp-1:0]             ram_data_i;

  modport slave (
    input  v_i, cmd_i, row_i, tag_set_i, way_i, tag_i, state_i, yumi_i,
           ram_ready_i, ram_data_i,
    output ready_o, v_o, old_tag_o, old_state_o, err_o,
           ram_v_o, ram_w_o, ram_addr_o, ram_data_o
  );

  modport master (
    output v_i, cmd_i, row_i, tag_set_i, way_i, tag_i, state_i, yumi_i,
           ram_ready_i, ram_data_i,
    input  ready_o, v_o, old_tag_o, old_state_o, err_o,
           ram_v_o, ram_w_o, ram_addr_o, ram_data_o
  );
endinterface

// File: rtl/bp_cce_dir_row_updater.sv
// Read-modify-write of one directory row: write tag+state, write state only,
// or invalidate a whole tag set; the prior entry is returned to the CCE.
//
// state  | meaning
// READY  | accepting a request
// READ   | RAM read of the addressed row, held until ram_ready_i
// MODIFY | read data arrives; old entry latched, modified row built
// WRITE  | RAM write of the modified row, held until ram_ready_i
// RESP   | response valid until yumi_i
module bp_cce_dir_row_updater
  import bp_cce_dir_pkg::*;
#(
  parameter int tag_sets_per_row_p = 2,
  parameter int assoc_p            = 2,
  parameter int tag_width_p        = 8,
  parameter int rows_p             = 4
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bp_cce_dir_row_updater_if.slave io
);
  localparam int state_width_lp  = $bits(bp_coh_states_e);
  localparam int entry_width_lp  = tag_width_p + state_width_lp;
  localparam int row_width_lp    = tag_sets_per_row_p * assoc_p * entry_width_lp;
  localparam int addr_width_lp   = (rows_p > 1) ? $clog2(rows_p) : 1;
  // row_i has one spare bit so an out-of-range row is expressible for any rows_p
  localparam int row_in_width_lp = addr_width_lp + 1;
  localparam int set_width_lp    = (tag_sets_per_row_p > 1) ? $clog2(tag_sets_per_row_p) : 1;
  localparam int way_width_lp    = (assoc_p > 1) ? $clog2(assoc_p) : 1;
  localparam logic [row_in_width_lp-1:0] rows_lim_lp = row_in_width_lp'(rows_p);

  typedef enum logic [2:0] {READY, READ, MODIFY, WRITE, RESP} state_e;

  state_e                    state_q, state_d;
  logic [1:0]                cmd_q, cmd_d;
  logic [addr_width_lp-1:0]  row_q, row_d;
  logic [set_width_lp-1:0]   set_q, set_d;
  logic [way_width_lp-1:0]   way_q, way_d;
  logic [tag_width_p-1:0]    tag_q, tag_d;
  bp_coh_states_e            st_q, st_d;
  logic [row_width_lp-1:0]   data_q, data_d;
  logic [tag_width_p-1:0]    old_tag_q, old_tag_d;
  bp_coh_states_e            old_st_q, old_st_d;
  logic                      err_q, err_d;

  logic [row_width_lp-1:0]   mod_row;
  logic [entry_width_lp-1:0] old_entry;
  logic [entry_width_lp-1:0] ent;

  always_comb begin
    mod_row   = io.ram_data_i;
    old_entry = '0;
    ent       = '0;
    for (int i = 0; i < tag_sets_per_row_p; i++) begin
      for (int j = 0; j < assoc_p; j++) begin
        ent = io.ram_data_i[(i*assoc_p+j)*entry_width_lp +: entry_width_lp];
        if (set_width_lp'(i) == set_q && way_width_lp'(j) == way_q) begin
          old_entry = ent;
          if (cmd_q == 2'd0)      ent = {tag_q, st_q};
          else if (cmd_q == 2'd1) ent[state_width_lp-1:0] = st_q;
        end
        if (cmd_q == 2'd2 && set_width_lp'(i) == set_q)
          ent = {{tag_width_p{1'b0}}, e_COH_I};
        mod_row[(i*assoc_p+j)*entry_width_lp +: entry_width_lp] = ent;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    row_d      = row_q;
    set_d      = set_q;
    way_d      = way_q;
    tag_d      = tag_q;
    st_d       = st_q;
    data_d     = data_q;
    old_tag_d  = old_tag_q;
    old_st_d   = old_st_q;
    err_d      = err_q;
    io.ready_o = 1'b0;
    io.v_o     = 1'b0;
    io.ram_v_o = 1'b0;
    io.ram_w_o = 1'b0;
    unique case (state_q)
      READY: begin
        io.ready_o = 1'b1;
        if (io.v_i) begin
          cmd_d = io.cmd_i;
          row_d = io.row_i[addr_width_lp-1:0];
          set_d = io.tag_set_i;
          way_d = io.way_i;
          tag_d = io.tag_i;
          st_d  = io.state_i;
          if (io.row_i >= rows_lim_lp || io.cmd_i == 2'd3) begin
            err_d     = 1'b1;
            old_tag_d = '0;
            old_st_d  = e_COH_I;
            state_d   = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = READ;
          end
        end
      end
      READ: begin
        io.ram_v_o = 1'b1;
        if (io.ram_ready_i) state_d = MODIFY;
      end
      MODIFY: begin
        data_d    = mod_row;
        old_tag_d = old_entry[entry_width_lp-1 -: tag_width_p];
        old_st_d  = bp_coh_states_e'(old_entry[state_width_lp-1:0]);
        state_d   = WRITE;
      end
      WRITE: begin
        io.ram_v_o = 1'b1;
        io.ram_w_o = 1'b1;
        if (io.ram_ready_i) state_d = RESP;
      end
      RESP: begin
        io.v_o = 1'b1;
        if (io.yumi_i) state_d = READY;
      end
      default: state_d = READY;
    endcase
  end

  // Outputs decode from async-reset state, so reset drops ram_v_o immediately
  assign io.ram_addr_o  = row_q;
  assign io.ram_data_o  = (state_q == WRITE) ? data_q : '0;
  assign io.old_tag_o   = old_tag_q;
  assign io.old_state_o = old_st_q;
  assign io.err_o       = err_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= READY;
      cmd_q     <= 2'd0;
      row_q     <= '0;
      set_q     <= '0;
      way_q     <= '0;
      tag_q     <= '0;
      st_q      <= e_COH_I;
      data_q    <= '0;
      old_tag_q <= '0;
      old_st_q  <= e_COH_I;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      row_q     <= row_d;
      set_q     <= set_d;
      way_q     <= way_d;
      tag_q     <= tag_d;
      st_q      <= st_d;
      data_q    <= data_d;
      old_tag_q <= old_tag_d;
      old_st_q  <= old_st_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_bp_cce_dir_row_updater.sv
// Bench for the directory row updater: a RAM responder with programmable
// stalls and a directory model kept as [row][set][way] entries.
`define CHK(t, o, e) chk(t, 64'(o), 64'(e))

module tb_bp_cce_dir_row_updater;
  import bp_cce_dir_pkg::*;

  localparam int SETS = 2;
  localparam int WAYS = 2;
  localparam int TW   = 8;
  localparam int ROWS = 4;
  localparam int EW   = TW + 3;
  localparam int RW   = SETS * WAYS * EW;

  typedef struct packed {
    logic [TW-1:0]  tag;
    bp_coh_states_e st;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bp_cce_dir_row_updater_if #(
    .tag_sets_per_row_p(SETS), .assoc_p(WAYS), .tag_width_p(TW), .rows_p(ROWS)
  ) bus ();

  bp_cce_dir_row_updater #(
    .tag_sets_per_row_p(SETS), .assoc_p(WAYS), .tag_width_p(TW), .rows_p(ROWS)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .io       (bus.slave)
  );

  ent_t           dir [ROWS][SETS][WAYS];
  logic [RW-1:0]  mem [ROWS];
  logic [RW-1:0]  last_wr;
  bp_coh_states_e sts [6] = '{e_COH_I, e_COH_S, e_COH_E, e_COH_F, e_COH_M, e_COH_O};
  int total = 0, passed = 0;
  int rd_cnt = 0, wr_cnt = 0, ramv_cycles = 0, rd_stall = 0, wr_stall = 0;

  function automatic logic [RW-1:0] pack_row(input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        v[(s*WAYS+w)*EW +: EW] = dir[r][s][w];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: RAM handshakes resolve at the edge, inputs change at the negedge
  task automatic tick;
    logic          hs_rd, hs_wr;
    logic [1:0]    a;
    logic [RW-1:0] d;
    hs_rd = bus.ram_v_o && bus.ram_ready_i && !bus.ram_w_o;
    hs_wr = bus.ram_v_o && bus.ram_ready_i && bus.ram_w_o;
    a = bus.ram_addr_o;
    d = bus.ram_data_o;
    @(posedge clk);
    #1;
    if (hs_wr) begin mem[a] = d; last_wr = d; wr_cnt++; end
    if (hs_rd) begin bus.ram_data_i = mem[a]; rd_cnt++; end
    @(negedge clk);
    if (bus.ram_v_o) ramv_cycles++;
    if (bus.ram_v_o && !bus.ram_w_o) begin
      bus.ram_ready_i = (rd_stall == 0);
      if (rd_stall > 0) rd_stall--;
    end else if (bus.ram_v_o) begin
      bus.ram_ready_i = (wr_stall == 0);
      if (wr_stall > 0) wr_stall--;
    end else begin
      bus.ram_ready_i = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_req(input int cmd, input int row, input int set, input int way,
                        input logic [TW-1:0] tag, input bp_coh_states_e st,
                        input int rs, input int ws, input int yw, input int exp_lat);
    bit            err;
    ent_t          old;
    logic [RW-1:0] exp_row;
    int            lat, rd0, wr0, rv0;
    exp_row = '0;
    err = (row >= ROWS) || (cmd == 3);
    if (err) begin
      old.tag = '0;
      old.st  = e_COH_I;
    end else begin
      old = dir[row][set][way];
      if (cmd == 0) begin
        dir[row][set][way].tag = tag;
        dir[row][set][way].st  = st;
      end else if (cmd == 1) begin
        dir[row][set][way].st = st;
      end else begin
        for (int w = 0; w < WAYS; w++) begin
          dir[row][set][w].tag = '0;
          dir[row][set][w].st  = e_COH_I;
        end
      end
      exp_row = pack_row(row);
    end
    rd_stall = rs; wr_stall = ws;
    rd0 = rd_cnt; wr0 = wr_cnt; rv0 = ramv_cycles;
    `CHK("ready_idle", bus.ready_o, 1'b1);
    bus.v_i       = 1'b1;
    bus.cmd_i     = 2'(cmd);
    bus.row_i     = 3'(row);
    bus.tag_set_i = 1'(set);
    bus.way_i     = 1'(way);
    bus.tag_i     = tag;
    bus.state_i   = st;
    tick;
    bus.v_i       = 1'b0;
    bus.cmd_i     = 2'($urandom);
    bus.row_i     = 3'($urandom);
    bus.tag_set_i = 1'($urandom);
    bus.way_i     = 1'($urandom);
    bus.tag_i     = 8'($urandom);
    bus.state_i   = e_COH_O;
    lat = 1;
    while (!bus.v_o && lat < 40) begin
      `CHK("busy_ready", bus.ready_o, 1'b0);
      if (bus.ram_v_o) `CHK("ram_addr", bus.ram_addr_o, row);
      if (bus.ram_v_o && bus.ram_w_o) `CHK("ram_wdata", bus.ram_data_o, exp_row);
      tick;
      lat++;
    end
    `CHK("v_o", bus.v_o, 1'b1);
    `CHK("latency", lat, exp_lat);
    `CHK("err_o", bus.err_o, err);
    `CHK("old_tag", bus.old_tag_o, old.tag);
    `CHK("old_state", bus.old_state_o, old.st);
    `CHK("resp_ready", bus.ready_o, 1'b0);
    `CHK("resp_ram_v", bus.ram_v_o, 1'b0);
    `CHK("rd_count", rd_cnt - rd0, err ? 0 : 1);
    `CHK("wr_count", wr_cnt - wr0, err ? 0 : 1);
    if (err) `CHK("err_no_ram_v", ramv_cycles - rv0, 0);
    else     `CHK("row_written", last_wr, exp_row);
    bus.yumi_i = 1'b0;
    repeat (yw) begin
      tick;
      `CHK("hold_v", bus.v_o, 1'b1);
      `CHK("hold_tag", bus.old_tag_o, old.tag);
      `CHK("hold_state", bus.old_state_o, old.st);
      `CHK("hold_err", bus.err_o, err);
    end
    bus.yumi_i = 1'b1;
    tick;
    bus.yumi_i = 1'b0;
    `CHK("v_drop", bus.v_o, 1'b0);
    `CHK("ready_back", bus.ready_o, 1'b1);
  endtask

  task automatic chk_reset_vals(input string pfx);
    `CHK({pfx, "_ready"},   bus.ready_o, 1'b1);
    `CHK({pfx, "_v"},       bus.v_o, 1'b0);
    `CHK({pfx, "_ram_v"},   bus.ram_v_o, 1'b0);
    `CHK({pfx, "_ram_w"},   bus.ram_w_o, 1'b0);
    `CHK({pfx, "_err"},     bus.err_o, 1'b0);
    `CHK({pfx, "_addr"},    bus.ram_addr_o, 2'd0);
    `CHK({pfx, "_data"},    bus.ram_data_o, 44'd0);
    `CHK({pfx, "_old_tag"}, bus.old_tag_o, 8'd0);
    `CHK({pfx, "_old_st"},  bus.old_state_o, e_COH_I);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, wr0, r, cmd, row, rs, ws;
    bus.v_i = 1'b0; bus.yumi_i = 1'b0; bus.cmd_i = 2'd0; bus.row_i = '0;
    bus.tag_set_i = '0; bus.way_i = '0; bus.tag_i = '0; bus.state_i = e_COH_I;
    bus.ram_ready_i = 1'b0; bus.ram_data_i = '0;
    for (int rr = 0; rr < ROWS; rr++)
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          dir[rr][s][w].tag = 8'($urandom);
          dir[rr][s][w].st  = sts[$urandom_range(0, 5)];
        end
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        dir[2][s][w].tag = 8'h11;
        dir[2][s][w].st  = e_COH_S;
      end
    dir[1][0][1].tag = 8'h5C; dir[1][0][1].st = e_COH_E;
    dir[3][0][0].tag = 8'h01; dir[3][0][0].st = e_COH_M;
    dir[3][0][1].tag = 8'h02; dir[3][0][1].st = e_COH_S;
    dir[3][1][0].tag = 8'h33; dir[3][1][0].st = e_COH_E;
    dir[3][1][1].tag = 8'h44; dir[3][1][1].st = e_COH_O;
    for (int rr = 0; rr < ROWS; rr++) mem[rr] = pack_row(rr);

    #1 rst_n = 1'b0;
    #1 chk_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Round trip on row 2, with the response held for 5 cycles
    do_req(0, 2, 1, 0, 8'hAB, e_COH_M, 0, 0, 5, 4);
    total++;
    if (last_wr === {11'h089, 11'h55E, 11'h089, 11'h089}) passed++;
    else $error("FAIL rt_row2_image: observed 0x%0h", last_wr);

    do_req(1, 1, 0, 1, 8'h77, e_COH_I, 0, 0, 0, 4);
    total++;
    if (last_wr[21:11] === 11'h2E0) passed++;
    else $error("FAIL state_only_entry: observed 0x%0h", last_wr[21:11]);

    do_req(2, 3, 0, 1, 8'h99, e_COH_M, 0, 0, 1, 4);
    total++;
    if (last_wr[21:0] === 22'd0) passed++;
    else $error("FAIL inval_set0: observed 0x%0h", last_wr[21:0]);
    total++;
    if (last_wr[43:22] === {11'h227, 11'h19A}) passed++;
    else $error("FAIL inval_set1_kept: observed 0x%0h", last_wr[43:22]);

    do_req(0, 0, 1, 1, 8'h3D, e_COH_E, 3, 2, 0, 9);

    do_req(0, 4, 0, 0, 8'h12, e_COH_M, 0, 0, 2, 1);
    do_req(3, 1, 1, 0, 8'h34, e_COH_S, 0, 0, 0, 1);

    // Reset while a write is stalled: no write may reach the RAM
    rd_stall = 0; wr_stall = 100;
    bus.v_i = 1'b1; bus.cmd_i = 2'd0; bus.row_i = 3'd1; bus.tag_set_i = 1'b1;
    bus.way_i = 1'b1; bus.tag_i = 8'hEE; bus.state_i = e_COH_M;
    tick;
    bus.v_i = 1'b0;
    n = 0;
    while (!bus.ram_w_o && n < 10) begin tick; n++; end
    `CHK("rst_reached_write", bus.ram_w_o, 1'b1);
    wr0 = wr_cnt;
    rst_n = 1'b0;
    #1 chk_reset_vals("midop");
    wr_stall = 0;
    tick;
    tick;
    total++;
    if (wr_cnt === wr0) passed++;
    else $error("FAIL rst_no_write: %0d writes after reset", wr_cnt - wr0);
    `CHK("rst_ram_v_low", bus.ram_v_o, 1'b0);
    rst_n = 1'b1;
    `CHK("rst_row1_intact", mem[1], pack_row(1));

    do_req(0, 1, 1, 1, 8'hC3, e_COH_F, 0, 0, 0, 4);

    for (int k = 0; k < 30; k++) begin
      r   = $urandom_range(0, 9);
      cmd = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
      row = $urandom_range(0, 4);
      rs  = $urandom_range(0, 3);
      ws  = $urandom_range(0, 3);
      do_req(cmd, row, $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom),
             sts[$urandom_range(0, 5)], rs, ws, $urandom_range(0, 3),
             (row >= ROWS || cmd == 3) ? 1 : 4 + rs + ws);
    end

    for (int rr = 0; rr < ROWS; rr++) begin
      total++;
      if (mem[rr] === pack_row(rr)) passed++;
      else $error("FAIL final_ram_image row %0d: observed 0x%0h expected 0x%0h",
                  rr, mem[rr], pack_row(rr));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
